// File: rtl/button_pkg.sv
// button_pkg
//   Shared definitions for the front-panel key event classifier:
//   the per-key press-state encoding and the default timing constants
//   for a 50 MHz system clock.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } press_state_t;

  // Defaults for a 50 MHz clock.
  localparam int DEF_N_KEYS       = 4;
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;   // 20 ms
  localparam int DEF_LONG_CYC     = 100_000_000; // 2 s
  localparam int DEF_REPEAT_CYC   = 10_000_000;  // 200 ms
  localparam int DEF_CNT_W        = 28;

endpackage

// File: rtl/button_channel.sv
// button_channel
//   One key channel: 2-FF synchroniser (inverted so 1 = pressed),
//   debouncer, and press-duration FSM producing one-cycle short, long
//   and (optionally) auto-repeat pulses.
//
//   Optional feature: define BUTTON_EVENTS_REPEAT_EN to build the
//   auto-repeat logic; otherwise repeat_pulse is constant 0.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   key           in   raw key pin, low = pressed
//   held          out  debounced pressed level, 1 = pressed
//   short_pulse   out  one-cycle pulse after release of a short press
//   long_pulse    out  one-cycle pulse when a press reaches LONG_CYC
//   repeat_pulse  out  one-cycle auto-repeat pulse while long-held
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic held,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  // Counters must be able to represent every terminal count.
  localparam longint MAX_CYC =
    (LONG_CYC > DEBOUNCE_CYC) ? ((LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC)
                              : ((DEBOUNCE_CYC > REPEAT_CYC) ? DEBOUNCE_CYC : REPEAT_CYC);

  if ((longint'(1) << CNT_W) <= MAX_CYC) begin : g_cnt_w_check
    $error("button_channel: CNT_W too narrow for the timing parameters");
  end

  // Synchroniser: stores the inverted key so the reset value 0 means released.
  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~key;
      sync2 <= sync1;
    end
  end

  // Debouncer
  logic [CNT_W-1:0] db_cnt;
  logic             db_done;
  logic             rise;

  assign db_done = (sync2 != held) && (db_cnt == DB_LAST);
  // Rise is the combinational toggle event, so the press FSM starts timing
  // in the same cycle held goes high.
  assign rise    = db_done && !held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      held   <= 1'b0;
    end else if (sync2 == held) begin
      db_cnt <= '0;
    end else if (db_done) begin
      db_cnt <= '0;
      held   <= ~held;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Press FSM
  press_state_t     state;
  press_state_t     state_nxt;
  logic [CNT_W-1:0] dur_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             short_nxt;
  logic             long_nxt;
`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
  logic             rep_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = dur_cnt;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
`ifdef BUTTON_EVENTS_REPEAT_EN
    rep_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS;
          cnt_nxt   = '0;
        end
      end
      PRESS: begin
        // Release is checked against the registered held, so the short
        // pulse lands one cycle after held falls. A release in the same
        // cycle as the long threshold is still seen as held = 1 -> long.
        if (!held) begin
          short_nxt = 1'b1;
          state_nxt = rise ? PRESS : IDLE;
          cnt_nxt   = '0;
        end else if (dur_cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = LONG;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = dur_cnt + 1'b1;
        end
      end
      LONG: begin
        // Without repeat the counter stays at 0 here, so it never wraps.
        if (!held) begin
          state_nxt = rise ? PRESS : IDLE;
          cnt_nxt   = '0;
        end
`ifdef BUTTON_EVENTS_REPEAT_EN
        else if (dur_cnt == REP_LAST) begin
          rep_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = dur_cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dur_cnt     <= '0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      state       <= state_nxt;
      dur_cnt     <= cnt_nxt;
      short_pulse <= short_nxt;
      long_pulse  <= long_nxt;
    end
  end

`ifdef BUTTON_EVENTS_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= rep_nxt;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_events.sv
// button_events
//   Multi-channel push-button event classifier. Each active-low key is
//   handled by an independent button_channel; this level only gathers
//   the per-channel outputs into vectors.
//
//   Optional feature: define BUTTON_EVENTS_REPEAT_EN to enable
//   auto-repeat pulses; otherwise repeat_pulse is constant 0.
//
// Ports
//   CLOCK_50      in   system clock (only clock)
//   rst_n         in   asynchronous active-low reset
//   key           in   [N_KEYS] raw keys, low = pressed
//   held          out  [N_KEYS] debounced pressed level
//   short_pulse   out  [N_KEYS] short-press event
//   long_pulse    out  [N_KEYS] long-press event
//   repeat_pulse  out  [N_KEYS] auto-repeat event
module button_events
  import button_pkg::*;
#(
  parameter int N_KEYS       = DEF_N_KEYS,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] held,
  output logic [N_KEYS-1:0] short_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk          (CLOCK_50),
      .rst_n        (rst_n),
      .key          (key[i]),
      .held         (held[i]),
      .short_pulse  (short_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: doc/button_events.md
# button_events

Multi-channel push-button event classifier for the front-panel keys of the clock design. Each of N_KEYS active-low key inputs is synchronised, debounced and timed. The block emits one-cycle event pulses for a short press, a long press and, optionally, auto-repeat. It sits between the raw key pins and the time-setting control logic.

## Interface
- N_KEYS, 4: number of independent key channels
- DEBOUNCE_CYC, 1_000_000: cycles the synchronised input must be stable before the debounced level changes (20 ms at 50 MHz)
- LONG_CYC, 100_000_000: press duration in cycles that qualifies as long (2 s)
- REPEAT_CYC, 10_000_000: auto-repeat period after the long threshold (200 ms); used only with the repeat feature
- CNT_W, 28: counter width; must satisfy 2^CNT_W > max(LONG_CYC, DEBOUNCE_CYC, REPEAT_CYC)
- CLOCK_50  in  1  system clock; the only clock in the block
- rst_n  in  1  asynchronous, active-low reset
- key  in  N_KEYS  raw keys, low = pressed
- held  out  N_KEYS  debounced pressed level, 1 = pressed
- short_pulse  out  N_KEYS  one-cycle pulse on release of a press shorter than LONG_CYC
- long_pulse  out  N_KEYS  one-cycle pulse when a press reaches LONG_CYC while still held
- repeat_pulse  out  N_KEYS  one-cycle auto-repeat pulse; tied to 0 when the repeat feature is compiled out

## Operation
- Channels are fully independent. There is no priority or interaction between keys.
- Synchroniser: a 2-FF chain per key, inverted so that s = 1 means pressed.
- Debounce:
  - The counter clears whenever s equals held.
  - It increments while s differs from held.
  - When it reaches DEBOUNCE_CYC-1, held toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes held.
- Press FSM states: IDLE, PRESS, LONG.
  - IDLE -> PRESS on the rising edge of held. The duration counter is loaded with 0.
  - PRESS: the counter increments every cycle.
    - When the counter reaches LONG_CYC-1: assert long_pulse and go to LONG.
    - On held falling before that point: assert short_pulse and go to IDLE.
  - LONG -> IDLE on held falling. No pulse is emitted at release.
- Exactly one of short_pulse or long_pulse is produced per debounced press, never both.
- The duration counter is not free-running. In LONG it is used only for repeat, so it cannot wrap.

## Timing
- Reset values: held, short_pulse, long_pulse and repeat_pulse are all 0; FSMs are in IDLE; all counters and synchroniser flops are cleared to the released state.
- Reset is asynchronous on assert. Deassertion is used as-is, because the board supplies a synchronised release.
- All outputs are registered.
- held rises 2+DEBOUNCE_CYC cycles after a clean falling edge on key.
- long_pulse is high in the cycle exactly LONG_CYC cycles after held rose.
- short_pulse is high in the cycle after held falls.
- Each pulse is exactly 1 cycle wide.
- A press whose debounced duration is exactly LONG_CYC-1 cycles is short. A press of LONG_CYC cycles or more is long.
- Reset asserted mid-press: all state is lost with no pulse. After reset, a key still held reads as a new press, which starts after the debounce delay.

## Configuration
- BUTTON_EVENTS_REPEAT_EN defined:
  - In LONG, the counter reloads 0 on entry.
  - repeat_pulse fires each time the counter reaches REPEAT_CYC-1, then the counter clears.
  - The first repeat pulse is therefore REPEAT_CYC cycles after long_pulse.
  - Repeats stop on release.
- Macro undefined: no repeat logic is generated, repeat_pulse is constant 0, and REPEAT_CYC is ignored.

## Structure
- Package button_pkg:
  - press-state enum (IDLE, PRESS, LONG);
  - default timing constants for 50 MHz.
- Sub-module button_channel: one synchroniser, debouncer, FSM and counters for a single key. It is instantiated N_KEYS times in a generate loop.
- The top level only concatenates the per-channel outputs.

## Test plan
All scenarios use small parameters: N_KEYS=2, DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5.
- Glitch: key[0] low for 3 cycles -> held[0] stays 0 and no pulses occur.
- Short press: key[0] low for 10 cycles, then high -> held[0] rises 6 cycles after the edge; short_pulse[0] fires once, 1 cycle after held falls; long_pulse stays 0.
- Long press: key[0] low for 40 cycles -> long_pulse[0] fires exactly 20 cycles after held rises, while the key is still low; no short_pulse on release.
- Threshold boundary: press trimmed so held is high for 19 cycles -> short_pulse only. Press with held high for 20 cycles -> long_pulse only.
- Repeat (macro on): key held for 50 cycles after held rises -> long_pulse at +20, repeat_pulse at +25, +30, …, +50, then stops on release. With the macro off, repeat_pulse stays 0.
- Independence and reset:
  - Overlapping presses on key[0] (short) and key[1] (long) -> correct pulses on each channel.
  - rst_n pulsed low mid long press -> all outputs 0 immediately.
  - Key still held after reset -> held rises again after 6 cycles; long_pulse follows 20 cycles later.
